// File: rtl/capture_trigger.sv
// Bus-cycle qualifier and trigger sequencer feeding the bus-capture buffer.
// Define CAPTURE_TRIG_DATA_MATCH_EN to add the data compare (sel 4/5) to the trigger.
module capture_trigger (
  input  logic        clk25,
  input  logic        res,
  input  logic        bus_strobe,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_dat,
  input  logic        bus_we,
  input  logic        bus_byte,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_sel,
  input  logic [15:0] cfg_dat,
  output logic [15:0] cap_addr,
  output logic [15:0] cap_dat,
  output logic [3:0]  flags,
  output logic        cap_wr,
  output logic [1:0]  trig_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] SEL_MADDR = 3'd0;
  localparam logic [2:0] SEL_AMASK = 3'd1;
  localparam logic [2:0] SEL_POST  = 3'd2;
  localparam logic [2:0] SEL_CTRL  = 3'd3;
`ifdef CAPTURE_TRIG_DATA_MATCH_EN
  localparam logic [2:0] SEL_MDAT  = 3'd4;
  localparam logic [2:0] SEL_DMASK = 3'd5;
`endif

  state_t      state, state_nxt;
  logic [15:0] match_addr;
  logic [15:0] addr_mask;
  logic [8:0]  post_cnt;
  logic        wr_only;
  logic        free_run;
  logic [8:0]  remaining, remaining_nxt;

  logic        skid_vld_p0;
  logic [15:0] skid_addr_p0;
  logic [15:0] skid_dat_p0;
  logic        skid_we_p0;
  logic        skid_byte_p0;
  logic        skid_trig_p0;
  logic        ovf;

  logic ctrl_wr;
  logic capturing;
  logic stb_live;
  logic addr_hit;
  logic dat_hit;
  logic match;
  logic skid_emit;
  logic direct;
  logic to_skid;
  logic drop;
  logic accept;
  logic trig_hit;

`ifdef CAPTURE_TRIG_DATA_MATCH_EN
  logic [15:0] match_dat;
  logic [15:0] dat_mask;
  assign dat_hit = ((bus_dat ^ match_dat) & dat_mask) == 16'h0000;
`else
  assign dat_hit = 1'b1;
`endif

  assign ctrl_wr   = cfg_wr && (cfg_sel == SEL_CTRL);
  assign capturing = (state == ST_ARMED) || (state == ST_POST);
  // A config write on the same clock swallows the strobe without flagging a drop.
  assign stb_live  = bus_strobe && !cfg_wr && capturing;
  assign addr_hit  = ((bus_addr ^ match_addr) & addr_mask) == 16'h0000;
  assign match     = addr_hit && dat_hit && (!wr_only || bus_we) && !free_run;

  // cap_wr high implies the skid is empty, so these four cases are exhaustive.
  assign skid_emit = skid_vld_p0 && !cap_wr;
  assign direct    = stb_live && !cap_wr && !skid_vld_p0;
  assign to_skid   = stb_live && cap_wr;
  assign drop      = stb_live && !cap_wr && skid_vld_p0;
  assign accept    = direct || to_skid;
  assign trig_hit  = accept && (state == ST_ARMED) && match;

  assign trig_state = state;

  always_ff @(posedge clk25) begin
    if (res) begin
      match_addr <= 16'h0000;
      addr_mask  <= 16'h0000;
      post_cnt   <= 9'd0;
      wr_only    <= 1'b0;
      free_run   <= 1'b0;
`ifdef CAPTURE_TRIG_DATA_MATCH_EN
      match_dat  <= 16'h0000;
      dat_mask   <= 16'h0000;
`endif
    end else if (cfg_wr) begin
      case (cfg_sel)
        SEL_MADDR: match_addr <= cfg_dat;
        SEL_AMASK: addr_mask  <= cfg_dat;
        SEL_POST:  post_cnt   <= cfg_dat[8:0];
        SEL_CTRL: begin
          wr_only  <= cfg_dat[1];
          free_run <= cfg_dat[2];
        end
`ifdef CAPTURE_TRIG_DATA_MATCH_EN
        SEL_MDAT:  match_dat  <= cfg_dat;
        SEL_DMASK: dat_mask   <= cfg_dat;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk25) begin
    if (res) begin
      state     <= ST_IDLE;
      remaining <= 9'd0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Trigger and post-trigger counting act on accepted strobes, not on emission.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    if (ctrl_wr) begin
      state_nxt = cfg_dat[0] ? ST_ARMED : ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_ARMED: begin
          if (match) begin
            remaining_nxt = post_cnt;
            state_nxt     = (post_cnt == 9'd0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          remaining_nxt = remaining - 9'd1;
          if (remaining == 9'd1) begin
            state_nxt = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0 -> output: direct emit or skid emit, one pulse with a gap after it.
  always_ff @(posedge clk25) begin
    if (res) begin
      cap_wr      <= 1'b0;
      cap_addr    <= 16'h0000;
      cap_dat     <= 16'h0000;
      flags       <= 4'h0;
      skid_vld_p0 <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      cap_wr <= 1'b0;
      if (ctrl_wr) begin
        skid_vld_p0 <= 1'b0;
        if (cfg_dat[0]) begin
          ovf <= 1'b0;
        end
      end else begin
        if (skid_emit) begin
          cap_wr      <= 1'b1;
          cap_addr    <= skid_addr_p0;
          cap_dat     <= skid_dat_p0;
          flags       <= {skid_trig_p0, skid_byte_p0, skid_we_p0, ovf};
          // A strobe lost on this clock is reported by the word after this one.
          ovf         <= drop;
          skid_vld_p0 <= 1'b0;
        end else if (direct) begin
          cap_wr   <= 1'b1;
          cap_addr <= bus_addr;
          cap_dat  <= bus_dat;
          flags    <= {trig_hit, bus_byte, bus_we, ovf};
          ovf      <= 1'b0;
        end
        if (to_skid) begin
          skid_vld_p0 <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (to_skid) begin
      skid_addr_p0 <= bus_addr;
      skid_dat_p0  <= bus_dat;
      skid_we_p0   <= bus_we;
      skid_byte_p0 <= bus_byte;
      skid_trig_p0 <= trig_hit;
    end
  end

endmodule

// File: tb/tb_capture_trigger.sv
// Self-checking bench for capture_trigger: vector table, directed corner sequences
// and randomized traffic against a timestamp-based reference model.
module tb_capture_trigger;

  logic        clk25 = 1'b0;
  logic        res = 1'b0, bus_strobe = 1'b0, bus_we = 1'b0, bus_byte = 1'b0, cfg_wr = 1'b0;
  logic [15:0] bus_addr = 16'h0, bus_dat = 16'h0, cfg_dat = 16'h0;
  logic [2:0]  cfg_sel = 3'd0;
  logic [15:0] cap_addr, cap_dat;
  logic [3:0]  flags;
  logic        cap_wr;
  logic [1:0]  trig_state;

  always #20 clk25 = ~clk25;

  capture_trigger dut (
    .clk25(clk25), .res(res), .bus_strobe(bus_strobe), .bus_addr(bus_addr),
    .bus_dat(bus_dat), .bus_we(bus_we), .bus_byte(bus_byte), .cfg_wr(cfg_wr),
    .cfg_sel(cfg_sel), .cfg_dat(cfg_dat), .cap_addr(cap_addr), .cap_dat(cap_dat),
    .flags(flags), .cap_wr(cap_wr), .trig_state(trig_state)
  );

  int n_tests = 0, n_fail = 0, cyc = 0, npulse = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted word gets an emission edge: no earlier than its own edge, at least
  // two edges after the previous word; it is dropped if that lands beyond edge+1.
  typedef struct {int e; logic [15:0] a; logic [15:0] d; logic t; logic b; logic w;} pend_t;
  pend_t pq[$];
  int    dq[$];
  int    last_out = -10;
  int    m_st = 0, m_rem = 0;
  logic [15:0] m_maddr = 0, m_amask = 0, m_mdat = 0, m_dmask = 0;
  logic [8:0]  m_post = 0;
  logic        m_wronly = 0, m_free = 0;
  logic        m_wr = 0;
  logic [15:0] m_addr = 0, m_dat = 0;
  logic [3:0]  m_flags = 0;

  task automatic m_step(input logic r, input logic s, input logic [15:0] a, input logic [15:0] d,
                        input logic w, input logic b, input logic cw, input logic [2:0] sel,
                        input logic [15:0] cd);
    int c, last, e, n;
    bit hit, dhit;
    pend_t p;
    c = cyc;
    m_wr = 1'b0;
    if (r) begin
      pq.delete(); dq.delete(); last_out = -10;
      m_st = 0; m_rem = 0; m_maddr = 0; m_amask = 0; m_mdat = 0; m_dmask = 0;
      m_post = 0; m_wronly = 0; m_free = 0; m_addr = 0; m_dat = 0; m_flags = 0;
      return;
    end
    if (cw) begin
      case (sel)
        3'd0: m_maddr = cd;
        3'd1: m_amask = cd;
        3'd2: m_post = cd[8:0];
        3'd3: begin
          while (pq.size() > 0 && pq[pq.size()-1].e >= c) pq.pop_back();
          if (cd[0]) dq.delete();
          m_st = cd[0] ? 1 : 0;
          m_wronly = cd[1];
          m_free = cd[2];
        end
`ifdef CAPTURE_TRIG_DATA_MATCH_EN
        3'd4: m_mdat = cd;
        3'd5: m_dmask = cd;
`endif
        default: ;
      endcase
    end else if (s && (m_st == 1 || m_st == 2)) begin
      last = (pq.size() > 0) ? pq[pq.size()-1].e : last_out;
      e = (c > last + 2) ? c : last + 2;
      if (e <= c + 1) begin
`ifdef CAPTURE_TRIG_DATA_MATCH_EN
        dhit = ((d ^ m_mdat) & m_dmask) == 16'h0;
`else
        dhit = 1'b1;
`endif
        hit = (m_st == 1) && !m_free && (((a ^ m_maddr) & m_amask) == 16'h0)
              && (!m_wronly || w) && dhit;
        pq.push_back('{e, a, d, hit, b, w});
        if (hit) begin
          m_rem = int'(m_post);
          m_st = (m_post == 0) ? 3 : 2;
        end else if (m_st == 2) begin
          m_rem--;
          if (m_rem == 0) m_st = 3;
        end
      end else begin
        dq.push_back(c);
      end
    end
    if (pq.size() > 0 && pq[0].e == c) begin
      p = pq.pop_front();
      n = 0;
      while (dq.size() > 0 && dq[0] < c) begin
        void'(dq.pop_front());
        n++;
      end
      m_wr = 1'b1; m_addr = p.a; m_dat = p.d;
      m_flags = {p.t, p.b, p.w, (n > 0)};
      last_out = c;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic r, input logic s, input logic [15:0] a, input logic [15:0] d,
                      input logic w, input logic b, input logic cw, input logic [2:0] sel,
                      input logic [15:0] cd);
    res = r; bus_strobe = s; bus_addr = a; bus_dat = d; bus_we = w; bus_byte = b;
    cfg_wr = cw; cfg_sel = sel; cfg_dat = cd;
    @(posedge clk25);
    m_step(r, s, a, d, w, b, cw, sel, cd);
    cyc++;
    #1;
    chk("model", {25'b0, cap_wr, cap_addr, cap_dat, flags, trig_state},
                 {25'b0, m_wr, m_addr, m_dat, m_flags, m_st[1:0]});
    if (cap_wr === 1'b1) npulse++;
  endtask

  task automatic idle();                      step(0, 0, 16'h0, 16'h0, 0, 0, 0, 3'd0, 16'h0); endtask
  task automatic rst();                       step(1, 0, 16'h0, 16'h0, 0, 0, 0, 3'd0, 16'h0); endtask
  task automatic cfg(input logic [2:0] sel, input logic [15:0] cd); step(0, 0, 16'h0, 16'h0, 0, 0, 1, sel, cd); endtask
  task automatic stb(input logic [15:0] a, input logic [15:0] d, input logic w, input logic b);
    step(0, 1, a, d, w, b, 0, 3'd0, 16'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic r, s; logic [15:0] a, d; logic w, b, cw; logic [2:0] sel; logic [15:0] cd;
    logic ewr; logic [1:0] est; logic [3:0] efl; logic [15:0] ead;
  } vec_t;
  vec_t tv[$];

  task automatic addv(input logic r, input logic s, input logic [15:0] a, input logic w,
                      input logic cw, input logic [2:0] sel, input logic [15:0] cd,
                      input logic ewr, input logic [1:0] est, input logic [3:0] efl,
                      input logic [15:0] ead);
    tv.push_back('{r, s, a, a ^ 16'h5A5A, w, 1'b0, cw, sel, cd, ewr, est, efl, ead});
  endtask

  // Strobe row followed by three quiet rows holding the same visible state.
  task automatic tstb(input logic [15:0] a, input logic ewr, input logic [1:0] est,
                      input logic [3:0] efl, input logic [15:0] ead);
    addv(0, 1, a, 1, 0, 3'd0, 16'h0, ewr, est, efl, ead);
    for (int i = 0; i < 3; i++) addv(0, 0, 16'h0, 0, 0, 3'd0, 16'h0, 0, est, efl, ead);
  endtask

  logic        r_r, r_s, r_w, r_b, r_cw;
  logic [2:0]  r_sel;
  logic [15:0] r_a, r_d, r_cd;
  int          k, np0;
  logic [15:0] a1;
  logic [3:0]  f1;

  initial begin
    // table: reset, idle strobes, address trigger with three post words
    addv(1, 0, 16'h0, 0, 0, 3'd0, 16'h0, 0, 2'd0, 4'h0, 16'h0);
    for (int i = 0; i < 10; i++) addv(0, 1, 16'h1000 + 16'(i * 2), 1, 0, 3'd0, 16'h0, 0, 2'd0, 4'h0, 16'h0);
    addv(0, 0, 16'h0, 0, 1, 3'd1, 16'hFFFF, 0, 2'd0, 4'h0, 16'h0);
    addv(0, 0, 16'h0, 0, 1, 3'd0, 16'h1000, 0, 2'd0, 4'h0, 16'h0);
    addv(0, 0, 16'h0, 0, 1, 3'd2, 16'h0003, 0, 2'd0, 4'h0, 16'h0);
    addv(0, 0, 16'h0, 0, 1, 3'd3, 16'h0001, 0, 2'd1, 4'h0, 16'h0);
    tstb(16'h0FFE, 1, 2'd1, 4'b0010, 16'h0FFE);
    tstb(16'h1000, 1, 2'd2, 4'b1010, 16'h1000);
    tstb(16'h1002, 1, 2'd2, 4'b0010, 16'h1002);
    tstb(16'h1004, 1, 2'd2, 4'b0010, 16'h1004);
    tstb(16'h1006, 1, 2'd3, 4'b0010, 16'h1006);
    tstb(16'h1008, 0, 2'd3, 4'b0010, 16'h1006);

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].s, tv[i].a, tv[i].d, tv[i].w, tv[i].b, tv[i].cw, tv[i].sel, tv[i].cd);
      chk("table", {27'b0, cap_wr, trig_state, flags, cap_addr},
                   {27'b0, tv[i].ewr, tv[i].est, tv[i].efl, tv[i].ead});
    end
    chk("table_pulses", 64'(npulse), 64'd5);

    // free-run burst on three consecutive clocks: third strobe dropped
    cfg(3'd3, 16'h0005);
    chk("fr_armed", 64'(trig_state), 64'd1);
    stb(16'h1100, 16'hA001, 0, 1);
    chk("fr_p1", {cap_wr, cap_addr}, {1'b1, 16'h1100});
    stb(16'h1102, 16'hA002, 1, 0);
    chk("fr_gap", 64'(cap_wr), 64'd0);
    stb(16'h1104, 16'hA003, 1, 0);
    chk("fr_p2", {cap_wr, cap_addr, cap_dat, flags}, {1'b1, 16'h1102, 16'hA002, 4'b0010});
    idle();
    chk("fr_gap2", 64'(cap_wr), 64'd0);
    stb(16'h1106, 16'hA004, 1, 1);
    chk("fr_ovf_word", {cap_wr, cap_addr, flags}, {1'b1, 16'h1106, 4'b0111});
    idle();
    stb(16'h1108, 16'hA005, 1, 1);
    chk("fr_ovf_clear", {cap_wr, flags}, {1'b1, 4'b0110});

    // post_cnt = 0: single trigger word then DONE
    cfg(3'd2, 16'h0000);
    cfg(3'd3, 16'h0001);
    idle();
    stb(16'h1000, 16'h0BEE, 1, 0);
    chk("p0_trig", {cap_wr, flags[3], trig_state}, {1'b1, 1'b1, 2'd3});
    idle();
    stb(16'h1000, 16'h0BEF, 1, 0);
    chk("p0_done", {cap_wr, trig_state}, {1'b0, 2'd3});

    // disarm on the same clock as a strobe during POST
    cfg(3'd2, 16'h0005);
    cfg(3'd3, 16'h0001);
    stb(16'h1000, 16'h1234, 1, 0);
    chk("dis_post", 64'(trig_state), 64'd2);
    idle();
    step(0, 1, 16'h1002, 16'h5555, 1, 0, 1, 3'd3, 16'h0000);
    chk("dis_idle", {cap_wr, trig_state}, {1'b0, 2'd0});
    idle();
    chk("dis_nopulse", 64'(cap_wr), 64'd0);

    // reset while a skid word is pending
    cfg(3'd3, 16'h0005);
    stb(16'h2000, 16'h1111, 1, 0);
    stb(16'h2002, 16'h2222, 1, 0);
    np0 = npulse;
    rst();
    idle(); idle(); idle();
    chk("rst_skid_pulses", 64'(npulse - np0), 64'd0);
    chk("rst_outputs", {cap_addr, cap_dat, flags, trig_state}, 38'h0);

    // data compare: spec order, then reversed order
    cfg(3'd1, 16'hFFFF); cfg(3'd0, 16'h3000); cfg(3'd2, 16'h0004);
    cfg(3'd4, 16'h0042); cfg(3'd5, 16'h00FF); cfg(3'd3, 16'h0001);
    stb(16'h3000, 16'h1242, 1, 0);
    chk("dm_a1", {cap_wr, flags[3]}, {1'b1, 1'b1});
    idle();
    stb(16'h3000, 16'h0043, 1, 0);
    chk("dm_a2", {cap_wr, flags[3]}, {1'b1, 1'b0});
    idle();
    cfg(3'd3, 16'h0001);
    stb(16'h3000, 16'h0043, 1, 0);
    a1 = 16'h0; f1 = flags;
    idle();
    stb(16'h3000, 16'h1242, 1, 0);
`ifdef CAPTURE_TRIG_DATA_MATCH_EN
    chk("dm_b", {f1[3], flags[3]}, {1'b0, 1'b1});
`else
    chk("dm_b", {f1[3], flags[3]}, {1'b1, 1'b0});
`endif

    // post_cnt = 511: trigger word plus 511 post words
    rst();
    cfg(3'd1, 16'hFFFF); cfg(3'd0, 16'h4000); cfg(3'd2, 16'h01FF); cfg(3'd3, 16'h0001);
    np0 = npulse;
    stb(16'h4000, 16'h0042, 1, 0);
    idle();
    for (int i = 0; i < 511; i++) begin
      if (i == 510) chk("p511_before_last", 64'(trig_state), 64'd2);
      stb(16'h4002, 16'(i), 0, 0);
      idle();
    end
    chk("p511_done", 64'(trig_state), 64'd3);
    chk("p511_pulses", 64'(npulse - np0), 64'd512);
    stb(16'h4002, 16'hFFFF, 0, 0);
    chk("p511_after", 64'(cap_wr), 64'd0);

    // randomized traffic checked cycle by cycle against the model
    rst();
    for (int i = 0; i < 4000; i++) begin
      r_r  = ($urandom_range(0, 299) == 0);
      r_cw = ($urandom_range(0, 24) == 0);
      r_s  = ($urandom_range(0, 2) != 0);
      r_a  = 16'h1000 + 16'(2 * $urandom_range(0, 7));
      r_d  = 16'($urandom);
      r_w  = 1'($urandom_range(0, 1));
      r_b  = 1'($urandom_range(0, 1));
      k    = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: r_sel = 3'd3;
        4: r_sel = 3'd0;
        5: r_sel = 3'd1;
        6: r_sel = 3'd2;
        7: r_sel = 3'd4;
        8: r_sel = 3'd5;
        default: r_sel = 3'd7;
      endcase
      case (r_sel)
        3'd0: r_cd = 16'h1000 + 16'(2 * $urandom_range(0, 7));
        3'd1: begin
          k = $urandom_range(0, 3);
          r_cd = (k == 0) ? 16'hFFFF : (k == 1) ? 16'hFFF0 : (k == 2) ? 16'h0000 : 16'hFFF8;
        end
        3'd2: r_cd = 16'($urandom_range(0, 6));
        3'd3: r_cd = {13'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) != 0)};
        3'd5: r_cd = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'h0003;
        default: r_cd = 16'($urandom);
      endcase
      step(r_r, r_s, r_a, r_d, r_w, r_b, r_cw, r_sel, r_cd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
